medidor_pwm: RTL and testbench

- Measurement end of the DPWM output path: samples a PWM waveform such as BUCK_Gate or Full_Bridge and recovers period, high time and duty cycle in percent.
- Used for closed-loop self-check of the DPWM on the board and as the value source for the 7-segment display path.
- Decodes what the DPWM encodes: a pin waveform in, numeric duty out.

---
 rtl/medidor_pwm.sv | 184 ++++++++++++++++++
 tb/tb_medidor_pwm.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/medidor_pwm.sv
// medidor_pwm: measures a PWM waveform and recovers period, high time and
// duty cycle in percent (floor(high*100/period)).
//
// Ports:
//   CLK_FPGA_BOARD   in   system clock, rising edge
//   reinicio         in   asynchronous active-low reset
//   pwm_in           in   asynchronous PWM waveform
//   periodo          out  last measured period in clocks (0 after timeout)
//   tiempo_alto      out  last measured high time in clocks (0 after timeout)
//   ciclo_trabajo    out  duty cycle in percent, 0..100
//   medicion_valida  out  one-cycle pulse when the outputs update
//   error_timeout    out  set by a stuck input, cleared by the next good result
//
// State    | meaning
// ESPERA   | waiting for the first rising edge; level is ignored
// MEDIR    | counting period/high time between rising edges

module medidor_pwm #(
  parameter int CNT_WIDTH   = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 CLK_FPGA_BOARD,
  input  logic                 reinicio,
  input  logic                 pwm_in,
  output logic [CNT_WIDTH-1:0] periodo,
  output logic [CNT_WIDTH-1:0] tiempo_alto,
  output logic [6:0]           ciclo_trabajo,
  output logic                 medicion_valida,
  output logic                 error_timeout
);

  localparam int DW  = CNT_WIDTH + 7;
  localparam int DCW = $clog2(DW + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [DCW-1:0]       DIV_ITERS = DCW'(DW);

  typedef enum logic {ESPERA, MEDIR} estado_t;

  // input synchronizer and edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_prev_q;
  logic                   s;
  logic                   flanco;

  assign s      = sync_q[SYNC_STAGES-1];
  assign flanco = s & ~s_prev_q;

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      sync_q   <= '0;
      s_prev_q <= 1'b0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      s_prev_q <= s;
    end
  end

  // measurement and divider state
  estado_t              estado_q, estado_d;
  logic [CNT_WIDTH-1:0] cnt_per_q, cnt_per_d;
  logic [CNT_WIDTH-1:0] cnt_alto_q, cnt_alto_d;
  logic [CNT_WIDTH-1:0] periodo_q, periodo_d;
  logic [CNT_WIDTH-1:0] alto_q, alto_d;
  logic [6:0]           ciclo_q, ciclo_d;
  logic                 valid_q, valid_d;
  logic                 err_q, err_d;
  logic [DCW-1:0]       div_cnt_q, div_cnt_d;
  logic [CNT_WIDTH-1:0] rem_q, rem_d;
  logic [DW-1:0]        dvd_q, dvd_d;

  logic                 div_busy;
  logic [CNT_WIDTH:0]   rem_sh;
  logic                 resta_ok;
  logic [CNT_WIDTH-1:0] rem_res;
  logic [DW-1:0]        q_next;

  always_comb begin
    estado_d   = estado_q;
    cnt_per_d  = cnt_per_q;
    cnt_alto_d = cnt_alto_q;
    periodo_d  = periodo_q;
    alto_d     = alto_q;
    ciclo_d    = ciclo_q;
    valid_d    = 1'b0;
    err_d      = err_q;
    div_cnt_d  = div_cnt_q;
    rem_d      = rem_q;
    dvd_d      = dvd_q;

    // restoring division step: dvd_q shifts dividend bits out at the top and
    // quotient bits in at the bottom; divisor is the held periodo_q
    div_busy = (div_cnt_q != '0);
    rem_sh   = {rem_q, dvd_q[DW-1]};
    resta_ok = (rem_sh >= {1'b0, periodo_q});
    rem_res  = CNT_WIDTH'(resta_ok ? (rem_sh - {1'b0, periodo_q}) : rem_sh);
    q_next   = {dvd_q[DW-2:0], resta_ok};

    if (div_busy) begin
      rem_d     = rem_res;
      dvd_d     = q_next;
      div_cnt_d = div_cnt_q - DCW'(1);
      if (div_cnt_q == DCW'(1)) begin
        // high time never exceeds the period, so the quotient fits in 7 bits
        ciclo_d = q_next[6:0];
        valid_d = 1'b1;
        err_d   = 1'b0;
      end
    end

    case (estado_q)
      ESPERA: begin
        if (flanco) begin
          cnt_per_d  = CNT_ONE;
          cnt_alto_d = CNT_ONE;
          estado_d   = MEDIR;
        end
      end
      MEDIR: begin
        if (flanco) begin
          cnt_per_d  = CNT_ONE;
          cnt_alto_d = CNT_ONE;
          // edges arriving while a division is in flight are decimated
          if (!div_busy) begin
            periodo_d = cnt_per_q;
            alto_d    = cnt_alto_q;
            dvd_d     = DW'(cnt_alto_q) * DW'(100);
            rem_d     = '0;
            div_cnt_d = DIV_ITERS;
          end
        end else if (cnt_per_q == CNT_MAX) begin
          // the divider cannot be busy here: it finishes long before saturation
          periodo_d = '0;
          alto_d    = '0;
          ciclo_d   = s ? 7'd100 : 7'd0;
          valid_d   = 1'b1;
          err_d     = 1'b1;
          estado_d  = ESPERA;
        end else begin
          cnt_per_d = cnt_per_q + CNT_ONE;
          if (s && (cnt_alto_q != CNT_MAX)) begin
            cnt_alto_d = cnt_alto_q + CNT_ONE;
          end
        end
      end
      default: estado_d = ESPERA;
    endcase
  end

  always_ff @(posedge CLK_FPGA_BOARD or negedge reinicio) begin
    if (!reinicio) begin
      estado_q   <= ESPERA;
      cnt_per_q  <= '0;
      cnt_alto_q <= '0;
      periodo_q  <= '0;
      alto_q     <= '0;
      ciclo_q    <= '0;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
      div_cnt_q  <= '0;
      rem_q      <= '0;
      dvd_q      <= '0;
    end else begin
      estado_q   <= estado_d;
      cnt_per_q  <= cnt_per_d;
      cnt_alto_q <= cnt_alto_d;
      periodo_q  <= periodo_d;
      alto_q     <= alto_d;
      ciclo_q    <= ciclo_d;
      valid_q    <= valid_d;
      err_q      <= err_d;
      div_cnt_q  <= div_cnt_d;
      rem_q      <= rem_d;
      dvd_q      <= dvd_d;
    end
  end

  assign periodo         = periodo_q;
  assign tiempo_alto     = alto_q;
  assign ciclo_trabajo   = ciclo_q;
  assign medicion_valida = valid_q;
  assign error_timeout   = err_q;

endmodule

// File: tb/tb_medidor_pwm.sv
// Testbench for medidor_pwm. The DUT runs with a 14-bit counter so that the
// stuck-input timeout is reached in about 16k clocks. The reference model
// works on pin-level rising edges: it derives each period and high time from
// edge timestamps and predicts when each result pulse must appear.

module tb_medidor_pwm;

  localparam int W       = 14;
  localparam int SYNC    = 2;
  localparam int MAXC    = (1 << W) - 1;
  localparam int DIV_LAT = W + 8;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] periodo;
  logic [W-1:0] tiempo_alto;
  logic [6:0]   ciclo;
  logic         valid;
  logic         err;

  medidor_pwm #(.CNT_WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .CLK_FPGA_BOARD (clk),
    .reinicio       (rst_n),
    .pwm_in         (pwm_in),
    .periodo        (periodo),
    .tiempo_alto    (tiempo_alto),
    .ciclo_trabajo  (ciclo),
    .medicion_valida(valid),
    .error_timeout  (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    int per;
    int hi;
    int duty;
    int err;
  } pulse_t;

  pulse_t exp_q[$];
  pulse_t got_q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  // model state
  bit armed      = 1'b0;
  bit prev_lvl   = 1'b0;
  int last_edge  = 0;
  int high_cnt   = 0;
  int busy_until = 0;
  int exp_err    = 0;

  always @(posedge clk) begin
    pulse_t p;
    cyc++;
    #2;
    if (valid === 1'b1) begin
      p.cyc  = cyc;
      p.per  = int'(periodo);
      p.hi   = int'(tiempo_alto);
      p.duty = int'(ciclo);
      p.err  = int'(err);
      got_q.push_back(p);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // one clock of stimulus plus the reference model update for that level
  task automatic tick(input bit lvl);
    pulse_t p;
    @(negedge clk);
    pwm_in = lvl;
    if (lvl && !prev_lvl) begin
      if (armed && cyc >= busy_until) begin
        p.cyc  = cyc + SYNC + DIV_LAT;
        p.per  = cyc - last_edge;
        p.hi   = high_cnt;
        p.duty = (high_cnt * 100) / (cyc - last_edge);
        p.err  = 0;
        exp_q.push_back(p);
        busy_until = cyc + DIV_LAT;
        exp_err = 0;
      end
      armed     = 1'b1;
      last_edge = cyc;
      high_cnt  = 0;
    end else if (armed && (cyc - last_edge == MAXC)) begin
      p.cyc  = cyc + SYNC + 1;
      p.per  = 0;
      p.hi   = 0;
      p.duty = lvl ? 100 : 0;
      p.err  = 1;
      exp_q.push_back(p);
      armed   = 1'b0;
      exp_err = 1;
    end
    if (lvl) high_cnt++;
    prev_lvl = lvl;
  endtask

  task automatic drive_pwm(input int per, input int hi, input int n);
    for (int p = 0; p < n; p++)
      for (int t = 0; t < per; t++)
        tick(t < hi);
  endtask

  task automatic hold(input bit lvl, input int n);
    for (int i = 0; i < n; i++) tick(lvl);
  endtask

  task automatic check_phase(input string tag);
    chk({tag, "/npulses"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      chk($sformatf("%s/%0d/cycle", tag, i), got_q[i].cyc,  exp_q[i].cyc);
      chk($sformatf("%s/%0d/periodo", tag, i), got_q[i].per,  exp_q[i].per);
      chk($sformatf("%s/%0d/alto", tag, i), got_q[i].hi,   exp_q[i].hi);
      chk($sformatf("%s/%0d/duty", tag, i), got_q[i].duty, exp_q[i].duty);
      chk($sformatf("%s/%0d/err", tag, i), got_q[i].err,  exp_q[i].err);
    end
    chk({tag, "/err_level"}, err, exp_err);
    exp_q.delete();
    got_q.delete();
  endtask

  initial begin
    int per;
    int hi;
    pulse_t keep[$];

    // reset state
    repeat (3) @(negedge clk);
    chk("rst/periodo", periodo, 0);
    chk("rst/alto", tiempo_alto, 0);
    chk("rst/duty", ciclo, 0);
    chk("rst/valid", valid, 0);
    chk("rst/err", err, 0);
    @(negedge clk);
    rst_n = 1'b1;
    hold(0, 4);

    // 25% duty; first edge only arms
    drive_pwm(100, 25, 3);
    hold(0, 40);
    check_phase("duty25");

    // truncation cases
    drive_pwm(300, 100, 3);
    drive_pwm(200, 199, 3);
    hold(0, 40);
    check_phase("trunc");

    // stuck high, stuck low, then recovery
    hold(1, MAXC + 8);
    check_phase("stuck_hi");
    hold(0, 5);
    tick(1);
    hold(0, MAXC + 8);
    check_phase("stuck_lo");
    drive_pwm(100, 40, 3);
    hold(0, 40);
    check_phase("resume");

    // decimation of short periods and the minimum accepted period
    drive_pwm(10, 5, 8);
    hold(0, 40);
    check_phase("decim10");
    drive_pwm(DIV_LAT, 11, 4);
    drive_pwm(DIV_LAT - 1, 7, 5);
    hold(0, 40);
    check_phase("min_period");

    // randomized waveforms
    for (int k = 0; k < 10; k++) begin
      per = $urandom_range(5, 400);
      hi  = $urandom_range(1, per - 1);
      drive_pwm(per, hi, $urandom_range(1, 4));
    end
    hold(0, 40);
    check_phase("random");

    // duty step between consecutive periods
    drive_pwm(100, 25, 2);
    drive_pwm(100, 75, 3);
    hold(0, 40);
    check_phase("step");

    // reset during a division
    drive_pwm(100, 25, 2);
    hold(1, 12);
    @(negedge clk);
    rst_n  = 1'b0;
    pwm_in = 1'b0;
    #1;
    chk("midrst/periodo", periodo, 0);
    chk("midrst/alto", tiempo_alto, 0);
    chk("midrst/duty", ciclo, 0);
    chk("midrst/valid", valid, 0);
    chk("midrst/err", err, 0);
    foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) keep.push_back(exp_q[i]);
    exp_q      = keep;
    armed      = 1'b0;
    prev_lvl   = 1'b0;
    busy_until = 0;
    exp_err    = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    hold(0, 40);
    drive_pwm(100, 30, 3);
    hold(0, 40);
    check_phase("after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
